// File: rtl/mest_pro_fetch_pkg.sv
// Shared types and field layout for the instruction fetch/sequencer stage.
// Holds the FSM state enum, default widths and the default instruction field slice positions.
package mest_pro_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_ISSUE,
        ST_WAIT,
        ST_HALTED
    } state_e;

    localparam int PC_W_DEF      = 8;
    localparam int OPC_W_DEF     = 5;
    localparam int OPA_W_DEF     = 8;
    localparam int OPB_W_DEF     = 8;
    localparam int RET_DEPTH_DEF = 4;
    localparam int INSTR_W_DEF   = OPC_W_DEF + OPA_W_DEF + OPB_W_DEF;

    // Default field layout: {opcode, operand1, operand2}, opcode at the top.
    localparam int OPC_MSB = INSTR_W_DEF - 1;
    localparam int OPC_LSB = INSTR_W_DEF - OPC_W_DEF;
    localparam int OPA_MSB = OPC_LSB - 1;
    localparam int OPA_LSB = OPB_W_DEF;
    localparam int OPB_MSB = OPB_W_DEF - 1;
    localparam int OPB_LSB = 0;

endpackage

// File: rtl/mest_pro_fetch_if.sv
// Instruction-memory and execute-unit bus of the fetch stage.
// master: fetch side (drives imem_en/addr, execute, decoded fields); slave: memory + execute unit.
interface mest_pro_fetch_if
    import mest_pro_fetch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int OPC_W   = OPC_W_DEF,
    parameter int OPA_W   = OPA_W_DEF,
    parameter int OPB_W   = OPB_W_DEF,
    parameter int INSTR_W = OPC_W + OPA_W + OPB_W
);

    logic               imem_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;

    logic               execute;
    logic [OPC_W-1:0]   op_code;
    logic [OPA_W-1:0]   operand1;
    logic [OPB_W-1:0]   operand2;
    logic [INSTR_W-1:0] load_reg;

    logic               exec_done;
    logic               jump;
    logic               return_pc;
    logic               end_of_code;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_data,
        output execute,
        output op_code,
        output operand1,
        output operand2,
        output load_reg,
        input  exec_done,
        input  jump,
        input  return_pc,
        input  end_of_code
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_data,
        input  execute,
        input  op_code,
        input  operand1,
        input  operand2,
        input  load_reg,
        output exec_done,
        output jump,
        output return_pc,
        output end_of_code
    );

endinterface

// File: rtl/mest_pro_ret_stack.sv
// Return-address LIFO used by JMP/RET pairs.
// Ports: clr_i (empty it), push_i/data_i, pop_i, top_o, full_o, empty_o. Push and pop never coincide.
module mest_pro_ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         i_reset_n,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] top_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_V = (AW + 1)'(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]   ptr_q;
    logic [AW:0]   ptr_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] top_idx;

    assign full_o  = (ptr_q == FULL_V);
    assign empty_o = (ptr_q == '0);
    assign top_idx = ptr_q[AW-1:0] - AW'(1);
    assign top_o   = mem_q[top_idx];

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (push_i && !full_o) begin
            ptr_d = ptr_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            ptr_d = ptr_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage needs no reset: nothing reads it until it was pushed.
    always_ff @(posedge clk) begin
        if (push_i && !full_o && !clr_i) begin
            mem_q[ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/mest_pro_fetch.sv
// Fetch/sequencer stage: owns the PC, reads imem, issues one execute strobe per instruction,
// picks the next PC from jump/return/halt flags. Ports: clk, i_reset_n, i_start(_pc), bus, status.
module mest_pro_fetch
    import mest_pro_fetch_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int OPC_W     = OPC_W_DEF,
    parameter int OPA_W     = OPA_W_DEF,
    parameter int OPB_W     = OPB_W_DEF,
    parameter int INSTR_W   = OPC_W + OPA_W + OPB_W,
    parameter int RET_DEPTH = RET_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [PC_W-1:0]   i_start_pc,
    mest_pro_fetch_if.master  bus,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_busy,
    output logic              o_halted,
    output logic              o_stack_err,
    output logic [15:0]       o_instr_count
);

    localparam int OPC_LO = INSTR_W - OPC_W;
    localparam int OPA_LO = OPB_W;

    state_e               state_q;
    state_e               state_d;
    logic [PC_W-1:0]      pc_q;
    logic [PC_W-1:0]      pc_d;
    logic [INSTR_W-1:0]   ir_q;
    logic [INSTR_W-1:0]   ir_d;
    logic [15:0]          cnt_q;
    logic [15:0]          cnt_d;
    logic                 err_q;
    logic                 err_d;

    logic                 start_acc;
    logic                 done_acc;
    logic [PC_W-1:0]      pc_inc;
    logic [OPA_W+OPB_W-1:0] opnd_cat;
    logic [PC_W-1:0]      jmp_tgt;

    logic                 stk_clr;
    logic                 stk_push;
    logic                 stk_pop;
    logic [PC_W-1:0]      stk_top;
    logic                 stk_full;
    logic                 stk_empty;

    mest_pro_ret_stack #(
        .DEPTH (RET_DEPTH),
        .W     (PC_W)
    ) u_ret_stack (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .clr_i     (stk_clr),
        .push_i    (stk_push),
        .pop_i     (stk_pop),
        .data_i    (pc_inc),
        .top_o     (stk_top),
        .full_o    (stk_full),
        .empty_o   (stk_empty)
    );

    // Decoded fields come straight from the instruction register.
    assign bus.op_code   = ir_q[INSTR_W-1 -: OPC_W];
    assign bus.operand1  = ir_q[OPA_LO +: OPA_W];
    assign bus.operand2  = ir_q[OPB_W-1:0];
    assign bus.load_reg  = ir_q;
    assign bus.imem_addr = pc_q;

    assign o_pc          = pc_q;
    assign o_stack_err   = err_q;
    assign o_instr_count = cnt_q;

    assign start_acc = i_start &&
                       ((state_q == ST_IDLE) || (state_q == ST_HALTED));
    assign done_acc  = bus.exec_done && (state_q == ST_WAIT);
    assign pc_inc    = pc_q + 1'b1;
    assign opnd_cat  = {bus.operand1, bus.operand2};
    assign jmp_tgt   = opnd_cat[PC_W-1:0];

    // FSM: state register
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE,
            ST_HALTED: if (start_acc) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_LATCH;
            ST_LATCH:  state_d = ST_ISSUE;
            ST_ISSUE:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (done_acc) begin
                    state_d = bus.end_of_code ? ST_HALTED : ST_FETCH;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.imem_en = 1'b0;
        bus.execute = 1'b0;
        o_busy      = 1'b1;
        o_halted    = 1'b0;
        unique case (state_q)
            ST_IDLE:   o_busy = 1'b0;
            ST_HALTED: begin
                o_busy   = 1'b0;
                o_halted = 1'b1;
            end
            ST_FETCH:  bus.imem_en = 1'b1;
            ST_ISSUE:  bus.execute = 1'b1;
            default:   ;
        endcase
    end

    // Datapath next-state: PC selection, IR capture, retire count, stack control.
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        stk_clr  = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;

        if (start_acc) begin
            pc_d    = i_start_pc;
            err_d   = 1'b0;
            stk_clr = 1'b1;
        end

        if (state_q == ST_LATCH) begin
            ir_d = bus.imem_data;
        end

        if (done_acc) begin
            cnt_d = cnt_q + 16'd1;
            if (bus.end_of_code) begin
                pc_d = pc_q;
            end else if (bus.jump) begin
                // On overflow the jump is still taken; the return is lost.
                pc_d = jmp_tgt;
                if (stk_full) begin
                    err_d = 1'b1;
                end else begin
                    stk_push = 1'b1;
                end
            end else if (bus.return_pc) begin
                if (stk_empty) begin
                    err_d = 1'b1;
                    pc_d  = pc_inc;
                end else begin
                    stk_pop = 1'b1;
                    pc_d    = stk_top;
                end
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pc_q  <= '0;
            ir_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // OPC_LO documents where the opcode field starts.
    localparam int OPC_LO_CHK = OPC_LO;

endmodule

// File: tb/tb_mest_pro_fetch.sv
// Self-checking bench for mest_pro_fetch: imem model, execute-unit model and
// a fetch-address scoreboard, with one task per scenario.
`timescale 1ns/1ps
module tb_mest_pro_fetch;
    import mest_pro_fetch_pkg::*;

    localparam logic [4:0] OP_ADD = 5'h01;
    localparam logic [4:0] OP_JMP = 5'h02;
    localparam logic [4:0] OP_RET = 5'h03;
    localparam logic [4:0] OP_HLT = 5'h1F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  start_pc = 8'h00;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        serr;
    logic [15:0] icnt;

    mest_pro_fetch_if bus ();

    mest_pro_fetch dut (
        .clk           (clk),
        .i_reset_n     (rst_n),
        .i_start       (start),
        .i_start_pc    (start_pc),
        .bus           (bus),
        .o_pc          (pc),
        .o_busy        (busy),
        .o_halted      (halted),
        .o_stack_err   (serr),
        .o_instr_count (icnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;

    // ---------------- instruction memory model ----------------
    logic [INSTR_W_DEF-1:0] mem [256];

    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_data <= mem[bus.imem_addr];
    end

    function automatic logic [INSTR_W_DEF-1:0] mk(
        input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        return {op, a, b};
    endfunction

    // ---------------- execute unit model ----------------
    int   exec_delay = 1;
    int   ecnt;
    logic epend;
    logic m_done;
    logic man_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_done <= 1'b0;
            epend  <= 1'b0;
            ecnt   <= 0;
        end else begin
            m_done <= 1'b0;
            if (bus.execute) begin
                if (exec_delay <= 1) m_done <= 1'b1;
                else begin
                    epend <= 1'b1;
                    ecnt  <= exec_delay - 1;
                end
            end else if (epend) begin
                if (ecnt <= 1) begin
                    m_done <= 1'b1;
                    epend  <= 1'b0;
                end else ecnt <= ecnt - 1;
            end
        end
    end

    assign bus.exec_done   = m_done | man_done;
    assign bus.jump        = m_done && (bus.op_code == OP_JMP);
    assign bus.return_pc   = m_done && (bus.op_code == OP_RET);
    assign bus.end_of_code = m_done && (bus.op_code == OP_HLT);

    // ---------------- fetch scoreboard / execute monitor ----------------
    logic [7:0] exp_q [$];
    logic [7:0] exp_a;
    int cyc = 0;
    int last_exec = -1;
    bit gap_chk = 1'b0;
    int exec_pulses = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.imem_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL fetch_unexpected addr=%h required=none", bus.imem_addr);
            end else begin
                exp_a = exp_q.pop_front();
                if (bus.imem_addr !== exp_a) begin
                    failures++;
                    $display("FAIL fetch_addr got=%h required=%h", bus.imem_addr, exp_a);
                end
            end
        end
        if (bus.execute) begin
            exec_pulses++;
            if (gap_chk && last_exec >= 0) begin
                checks++;
                if (cyc - last_exec != 4) begin
                    failures++;
                    $display("FAIL exec_gap got=%0d required=4", cyc - last_exec);
                end
            end
            last_exec = cyc;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] a);
        start_pc = a;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_halted(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (halted) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({busy, halted, serr, bus.execute, bus.imem_en} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b required=00000",
                     {busy, halted, serr, bus.execute, bus.imem_en});
        end
        checks++;
        if ({pc, icnt, bus.imem_addr, bus.load_reg} !== '0) begin
            failures++;
            $display("FAIL reset_regs pc=%h cnt=%h addr=%h ir=%h required=0",
                     pc, icnt, bus.imem_addr, bus.load_reg);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_straight();
        bit ok;
        mem[8'h10] = mk(OP_ADD, 8'h01, 8'h02);
        mem[8'h11] = mk(OP_ADD, 8'h03, 8'h04);
        mem[8'h12] = mk(OP_ADD, 8'h05, 8'h06);
        mem[8'h13] = mk(OP_HLT, 8'h00, 8'h00);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h13);
        gap_chk   = 1'b1;
        last_exec = -1;
        do_start(8'h10);
        wait_halted(200, ok);
        gap_chk = 1'b0;
        exp_cnt += 4;
        checks++;
        if (!ok) begin failures++; $display("FAIL straight_halt_timeout got=0 required=1"); end
        checks++;
        if (icnt !== 16'(exp_cnt)) begin
            failures++; $display("FAIL straight_count got=%0d required=%0d", icnt, exp_cnt);
        end
        checks++;
        if (pc !== 8'h13) begin failures++; $display("FAIL straight_pc got=%h required=13", pc); end
        checks++;
        if ({halted, busy} !== 2'b10) begin
            failures++; $display("FAIL straight_status got=%b required=10", {halted, busy});
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL straight_fetches left=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_jmp_ret();
        bit ok;
        mem[8'h05] = mk(OP_JMP, 8'h00, 8'h40);
        mem[8'h40] = mk(OP_RET, 8'h00, 8'h00);
        mem[8'h06] = mk(OP_HLT, 8'h00, 8'h00);
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h06);
        do_start(8'h05);
        wait_halted(200, ok);
        exp_cnt += 3;
        checks++;
        if (!ok) begin failures++; $display("FAIL jmpret_halt_timeout got=0 required=1"); end
        checks++;
        if (serr !== 1'b0) begin failures++; $display("FAIL jmpret_err got=%b required=0", serr); end
        checks++;
        if ({pc, icnt} !== {8'h06, 16'(exp_cnt)}) begin
            failures++; $display("FAIL jmpret_pc_cnt got=%h/%0d required=06/%0d", pc, icnt, exp_cnt);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL jmpret_fetches left=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_overflow();
        bit ok;
        mem[8'h80] = mk(OP_JMP, 8'h00, 8'h90);
        mem[8'h90] = mk(OP_JMP, 8'h00, 8'hA0);
        mem[8'hA0] = mk(OP_JMP, 8'h00, 8'hB0);
        mem[8'hB0] = mk(OP_JMP, 8'h00, 8'hC0);
        mem[8'hC0] = mk(OP_JMP, 8'h00, 8'hD0);
        mem[8'hD0] = mk(OP_RET, 8'h00, 8'h00);
        mem[8'hB1] = mk(OP_HLT, 8'h00, 8'h00);
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h90);
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hB0);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hD0);
        exp_q.push_back(8'hB1);
        do_start(8'h80);
        wait_halted(300, ok);
        exp_cnt += 7;
        checks++;
        if (!ok) begin failures++; $display("FAIL ovf_halt_timeout got=0 required=1"); end
        checks++;
        if (serr !== 1'b1) begin failures++; $display("FAIL ovf_err got=%b required=1", serr); end
        checks++;
        if ({pc, icnt} !== {8'hB1, 16'(exp_cnt)}) begin
            failures++; $display("FAIL ovf_pc_cnt got=%h/%0d required=b1/%0d", pc, icnt, exp_cnt);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL ovf_fetches left=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_underflow();
        bit ok;
        mem[8'h60] = mk(OP_RET, 8'h00, 8'h00);
        mem[8'h61] = mk(OP_HLT, 8'h00, 8'h00);
        exp_q.push_back(8'h60);
        exp_q.push_back(8'h61);
        do_start(8'h60);
        tick();
        checks++;
        if (serr !== 1'b0) begin failures++; $display("FAIL unf_err_clear got=%b required=0", serr); end
        wait_halted(200, ok);
        exp_cnt += 2;
        checks++;
        if (!ok) begin failures++; $display("FAIL unf_halt_timeout got=0 required=1"); end
        checks++;
        if (serr !== 1'b1) begin failures++; $display("FAIL unf_err got=%b required=1", serr); end
        checks++;
        if ({pc, icnt} !== {8'h61, 16'(exp_cnt)}) begin
            failures++; $display("FAIL unf_pc_cnt got=%h/%0d required=61/%0d", pc, icnt, exp_cnt);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL unf_fetches left=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        bit ok;
        mem[8'hFF] = mk(OP_ADD, 8'h00, 8'h00);
        mem[8'h00] = mk(OP_HLT, 8'h00, 8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        do_start(8'hFF);
        wait_halted(200, ok);
        exp_cnt += 2;
        checks++;
        if (!ok) begin failures++; $display("FAIL wrap_halt_timeout got=0 required=1"); end
        checks++;
        if ({pc, serr, icnt} !== {8'h00, 1'b0, 16'(exp_cnt)}) begin
            failures++;
            $display("FAIL wrap_state got=%h/%b/%0d required=00/0/%0d", pc, serr, icnt, exp_cnt);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL wrap_fetches left=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit seen;
        mem[8'h50] = mk(OP_ADD, 8'h12, 8'h34);
        mem[8'h51] = mk(OP_HLT, 8'h00, 8'h00);
        exp_q.push_back(8'h50);
        exp_q.push_back(8'h51);
        exec_delay  = 10;
        exec_pulses = 0;
        do_start(8'h50);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.execute) begin seen = 1'b1; break; end
            tick();
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL stall_issue_timeout got=0 required=1"); end
        // A start while busy must not redirect fetch.
        start_pc = 8'h77;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({bus.op_code, bus.operand1, bus.operand2, bus.imem_en, bus.execute}
                !== {OP_ADD, 8'h12, 8'h34, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got=%h/%h/%h/%b/%b required=01/12/34/0/0",
                         i, bus.op_code, bus.operand1, bus.operand2, bus.imem_en, bus.execute);
            end
            tick();
        end
        wait_halted(300, ok);
        exec_delay = 1;
        exp_cnt += 2;
        checks++;
        if (!ok) begin failures++; $display("FAIL stall_halt_timeout got=0 required=1"); end
        checks++;
        if (exec_pulses != 2) begin
            failures++; $display("FAIL stall_exec_pulses got=%0d required=2", exec_pulses);
        end
        checks++;
        if ({pc, icnt} !== {8'h51, 16'(exp_cnt)}) begin
            failures++; $display("FAIL stall_pc_cnt got=%h/%0d required=51/%0d", pc, icnt, exp_cnt);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL stall_fetches left=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_reset_wait();
        bit seen;
        mem[8'h30] = mk(OP_ADD, 8'h0A, 8'h0B);
        exp_q.push_back(8'h30);
        exec_delay = 50;
        do_start(8'h30);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.execute) begin seen = 1'b1; break; end
            tick();
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL rstw_issue_timeout got=0 required=1"); end
        tick();
        tick();
        man_done = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        checks++;
        if ({busy, halted, serr, bus.execute, bus.imem_en} !== 5'b0) begin
            failures++;
            $display("FAIL rstw_flags got=%b required=00000",
                     {busy, halted, serr, bus.execute, bus.imem_en});
        end
        checks++;
        if ({pc, icnt, bus.op_code, bus.operand1, bus.operand2, bus.load_reg} !== '0) begin
            failures++;
            $display("FAIL rstw_regs pc=%h cnt=%0d op=%h a=%h b=%h ir=%h required=0",
                     pc, icnt, bus.op_code, bus.operand1, bus.operand2, bus.load_reg);
        end
        man_done = 1'b0;
        tick();
        rst_n = 1'b1;
        exec_delay = 1;
        repeat (4) tick();
        checks++;
        if ({busy, halted, icnt} !== {2'b00, 16'(exp_cnt)}) begin
            failures++;
            $display("FAIL rstw_idle got=%b/%0d required=00/0", {busy, halted}, icnt);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL rstw_fetches left=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = mk(OP_HLT, 8'h00, 8'h00);
        test_reset();
        test_straight();
        test_jmp_ret();
        test_overflow();
        test_underflow();
        test_wrap();
        test_stall();
        test_reset_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
